// File: rtl/button_pulse_gen_pkg.sv
// Shared definitions for the button conditioning block: pulse FSM state
// encodings and the counter-width helper, also reused by the counter bench.
package button_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  // Bits needed to hold values 0..x-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/button_pulse_gen_if.sv
// Button-side signal bundle.
//   btn_in : raw asynchronous push-button (driven by master)
//   level  : debounced button state (driven by slave)
//   pulse  : one-cycle strobe to the counter enable (driven by slave)
interface button_pulse_gen_if;
  logic btn_in;
  logic level;
  logic pulse;

  modport master (output btn_in, input level, input pulse);
  modport slave  (input btn_in, output level, output pulse);
endinterface

// File: rtl/button_pulse_gen_sync_2ff.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
//   clk   : destination clock
//   reset : synchronous active-high reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      q      <= 1'b0;
    end else begin
      sync_a <= d;
      q      <= sync_a;
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// Push-button conditioner: synchronizes and debounces a raw button, then
// emits a one-cycle strobe per press plus optional auto-repeat strobes.
//   clk   : single clock
//   reset : synchronous active-high reset
//   bus   : slave side of button_pulse_gen_if (btn_in in; level, pulse out)
module button_pulse_gen
  import button_pulse_gen_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  button_pulse_gen_if.slave        bus
);

  localparam int unsigned STAB_W  = clog2_min1(STABLE_CYCLES);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = clog2_min1(RPT_MAX);

  localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [RPT_W-1:0]  DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0]  PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0]  RPT_SAT     = {RPT_W{1'b1}};

  logic              btn_s;
  logic              level_q;
  logic              level_nxt;
  logic [STAB_W-1:0] stab_cnt;
  logic [STAB_W-1:0] stab_cnt_nxt;
  state_e            state;
  state_e            state_nxt;
  logic [RPT_W-1:0]  rpt_cnt;
  logic [RPT_W-1:0]  rpt_cnt_nxt;
  logic              pulse_q;
  logic              pulse_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_in),
    .q     (btn_s)
  );

  // Debounce: level follows btn_s only after STABLE_CYCLES disagreeing samples.
  always_comb begin
    level_nxt    = level_q;
    stab_cnt_nxt = '0;
    if (btn_s != level_q) begin
      if (stab_cnt == STAB_LAST) begin
        level_nxt = btn_s;
      end else begin
        stab_cnt_nxt = stab_cnt + STAB_W'(1);
      end
    end
  end

  // Pulse FSM works on the level being committed this edge, so a falling
  // level always overrides a coincident repeat strobe.
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    pulse_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (level_nxt) begin
          pulse_nxt   = 1'b1;
          rpt_cnt_nxt = '0;
          state_nxt   = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!level_nxt) begin
          rpt_cnt_nxt = '0;
          state_nxt   = ST_IDLE;
        end else if ((REPEAT_DELAY != 0) && (rpt_cnt == DELAY_LAST)) begin
          pulse_nxt   = 1'b1;
          rpt_cnt_nxt = '0;
          state_nxt   = ST_REPEAT;
        end else if (rpt_cnt != RPT_SAT) begin
          rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!level_nxt) begin
          rpt_cnt_nxt = '0;
          state_nxt   = ST_IDLE;
        end else if (rpt_cnt == PERIOD_LAST) begin
          pulse_nxt   = 1'b1;
          rpt_cnt_nxt = '0;
        end else begin
          rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
        end
      end
      default: begin
        rpt_cnt_nxt = '0;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q  <= 1'b0;
      stab_cnt <= '0;
      state    <= ST_IDLE;
      rpt_cnt  <= '0;
      pulse_q  <= 1'b0;
    end else begin
      level_q  <= level_nxt;
      stab_cnt <= stab_cnt_nxt;
      state    <= state_nxt;
      rpt_cnt  <= rpt_cnt_nxt;
      pulse_q  <= pulse_nxt;
    end
  end

  assign bus.level = level_q;
  assign bus.pulse = pulse_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: three instances (defaults, auto-repeat off,
// minimal debounce with short repeat) share one button and are compared
// every cycle against a press-timing reference model.
module tb_button_pulse_gen;

  localparam int NI = 3;
  localparam int S_P [NI] = '{4, 4, 1};
  localparam int D_P [NI] = '{8, 0, 3};
  localparam int P_P [NI] = '{3, 3, 2};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b0;

  always #5 clk = ~clk;

  button_pulse_gen_if bus_a ();
  button_pulse_gen_if bus_b ();
  button_pulse_gen_if bus_c ();

  assign bus_a.btn_in = btn;
  assign bus_b.btn_in = btn;
  assign bus_c.btn_in = btn;

  button_pulse_gen #(.STABLE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  button_pulse_gen #(.STABLE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  button_pulse_gen #(.STABLE_CYCLES(1), .REPEAT_DELAY(3), .REPEAT_PERIOD(2))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  logic obs_lvl [NI];
  logic obs_pulse [NI];
  assign obs_lvl[0] = bus_a.level;
  assign obs_lvl[1] = bus_b.level;
  assign obs_lvl[2] = bus_c.level;
  assign obs_pulse[0] = bus_a.pulse;
  assign obs_pulse[1] = bus_b.pulse;
  assign obs_pulse[2] = bus_c.pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state: synchronizer stages, debounced level, length of
  // the current disagreeing run, cycles since the press strobe.
  int m_sa [NI];
  int m_sb [NI];
  int m_lvl [NI];
  int m_run [NI];
  int m_age [NI];
  int m_pulse [NI];

  // Per-scenario observations.
  int scn_idx;
  int pcnt [NI];
  int first_pulse [NI];
  int first_lvl [NI];
  int last_lvl [NI];
  int last_pulse [NI];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic b, input logic r);
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_sa[i] = 0; m_sb[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_age[i] = 0; m_pulse[i] = 0;
      end else begin
        int new_lvl;
        new_lvl = m_lvl[i];
        if (m_sb[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == S_P[i]) begin
            new_lvl  = m_sb[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        if (new_lvl == 1 && m_lvl[i] == 0) begin
          m_pulse[i] = 1;
          m_age[i]   = 0;
        end else if (new_lvl == 1) begin
          m_age[i]++;
          m_pulse[i] = (D_P[i] != 0 && m_age[i] >= D_P[i] &&
                        ((m_age[i] - D_P[i]) % P_P[i]) == 0) ? 1 : 0;
        end else begin
          m_pulse[i] = 0;
          m_age[i]   = 0;
        end
        m_lvl[i] = new_lvl;
        m_sb[i]  = m_sa[i];
        m_sa[i]  = b ? 1 : 0;
      end
    end
  endtask

  task automatic begin_scn();
    scn_idx = 0;
    for (int i = 0; i < NI; i++) begin
      pcnt[i] = 0; first_pulse[i] = -1; first_lvl[i] = -1; last_lvl[i] = -1; last_pulse[i] = -1;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cycle(input logic b, input logic r);
    btn   = b;
    reset = r;
    @(posedge clk);
    model_step(b, r);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("lvl%0d", i), 32'(obs_lvl[i]), 32'(m_lvl[i]));
      check($sformatf("pulse%0d", i), 32'(obs_pulse[i]), 32'(m_pulse[i]));
      if (obs_pulse[i] === 1'b1) begin
        pcnt[i]++;
        last_pulse[i] = scn_idx;
        if (first_pulse[i] < 0) first_pulse[i] = scn_idx;
      end
      if (obs_lvl[i] === 1'b1) begin
        last_lvl[i] = scn_idx;
        if (first_lvl[i] < 0) first_lvl[i] = scn_idx;
      end
    end
    scn_idx++;
  endtask

  task automatic run(input logic b, input int n);
    for (int k = 0; k < n; k++) cycle(b, 1'b0);
  endtask

  initial begin
    begin_scn();

    // Reset held two cycles with the button pressed.
    cycle(1'b1, 1'b1);
    check("rst_lvl", 32'(bus_a.level), 32'd0);
    check("rst_pulse", 32'(bus_a.pulse), 32'd0);
    cycle(1'b1, 1'b1);
    check("rst_pulse_hold", 32'(pcnt[0] + pcnt[1]), 32'd0);
    run(1'b0, 10);

    // Short glitch: three high cycles never reach STABLE_CYCLES samples.
    begin_scn();
    run(1'b1, 3);
    run(1'b0, 12);
    check("glitch_pulses", 32'(pcnt[0]), 32'd0);
    check("glitch_lvl", 32'(first_lvl[0]), 32'hFFFF_FFFF);

    // Bouncy press, released so that level falls on a would-be repeat edge.
    begin_scn();
    cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    run(1'b1, 8);
    run(1'b0, 16);
    check("bounce_first_lvl", 32'(first_lvl[0]), 32'd9);
    check("bounce_first_pulse", 32'(first_pulse[0]), 32'd9);
    check("bounce_pulses", 32'(pcnt[0]), 32'd1);
    check("bounce_pulses_norpt", 32'(pcnt[1]), 32'd1);

    // Hold 30 cycles then release.
    begin_scn();
    run(1'b1, 30);
    run(1'b0, 12);
    check("hold_first_pulse", 32'(first_pulse[0]), 32'd5);
    check("hold_pulses", 32'(pcnt[0]), 32'd9);
    check("hold_last_pulse", 32'(last_pulse[0]), 32'd34);
    check("hold_last_lvl", 32'(last_lvl[0]), 32'd34);
    check("hold_pulses_norpt", 32'(pcnt[1]), 32'd1);

    // Reset while in auto-repeat with the button still held.
    begin_scn();
    run(1'b1, 16);
    cycle(1'b1, 1'b1);
    check("rst_rpt_lvl", 32'(bus_a.level), 32'd0);
    check("rst_rpt_pulse", 32'(bus_a.pulse), 32'd0);
    cycle(1'b1, 1'b1);
    begin_scn();
    run(1'b1, 12);
    check("rst_rpt_first_pulse", 32'(first_pulse[0]), 32'd5);
    check("rst_rpt_pulses", 32'(pcnt[0]), 32'd1);
    run(1'b0, 12);

    // Back-to-back clean presses.
    begin_scn();
    for (int k = 0; k < 3; k++) begin
      run(1'b1, 8);
      run(1'b0, 8);
    end
    check("b2b_pulses", 32'(pcnt[0]), 32'd3);
    check("b2b_pulses_norpt", 32'(pcnt[1]), 32'd3);

    // Long hold: auto-repeat off gives one strobe.
    begin_scn();
    run(1'b1, 40);
    run(1'b0, 12);
    check("long_pulses_norpt", 32'(pcnt[1]), 32'd1);
    check("long_pulses", 32'(pcnt[0]), 32'd12);

    // Random runs of press/release with occasional resets.
    begin_scn();
    for (int k = 0; k < 300; k++) begin
      logic b;
      int len;
      b   = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        cycle(b, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end
    run(1'b0, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
